// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, load-type encodings and the hardwired zero register.
package mips_pkg;
    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int REG_ZERO = 0;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;
endpackage

// File: rtl/load_align.sv
// Big-endian sub-word load alignment and extension; byte 0 is [31:24], half 0 is [31:16].
module load_align
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr,
    input  logic [2:0]        ltype,
    output logic [DATA_W-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        // Half-word selection deliberately ignores addr[0].
        half_sel = addr[1] ? rdata[15:0] : rdata[31:16];

        case (ltype)
            LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  data = {24'd0, byte_sel};
            LT_LH:   data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback mux with forwarding tap and retired counter.
// Optional feature: define WB_LOAD_EXT_EN for sub-word load alignment via load_align.
module wb_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_regwrite,
    input  logic              mem_memtoreg,
    input  logic [REG_W-1:0]  mem_writereg,
    input  logic [DATA_W-1:0] mem_aluresult,
    input  logic [DATA_W-1:0] mem_readdata,
`ifdef WB_LOAD_EXT_EN
    input  logic [2:0]        mem_loadtype,
`endif
    output logic [REG_W-1:0]  writereg,
    output logic [DATA_W-1:0] writedata,
    output logic              write,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retired
);
    import mips_pkg::*;

    logic              wb_valid_q,    wb_valid_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic              wb_memtoreg_q, wb_memtoreg_d;
    logic [REG_W-1:0]  wb_writereg_q, wb_writereg_d;
    logic [DATA_W-1:0] wb_alu_q,      wb_alu_d;
    logic [DATA_W-1:0] wb_rdata_q,    wb_rdata_d;
    logic [31:0]       retired_q,     retired_d;
    logic [DATA_W-1:0] load_data;
    logic              retire;
`ifdef WB_LOAD_EXT_EN
    logic [2:0]        wb_ltype_q,    wb_ltype_d;
`endif

    // An entry completes when it leaves WB unstalled and unflushed, whether or not it writes.
    assign retire = wb_valid_q & ~stall & ~flush;

    always_comb begin
        wb_valid_d    = wb_valid_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_writereg_d = wb_writereg_q;
        wb_alu_d      = wb_alu_q;
        wb_rdata_d    = wb_rdata_q;
`ifdef WB_LOAD_EXT_EN
        wb_ltype_d    = wb_ltype_q;
`endif
        retired_d     = retire ? retired_q + 32'd1 : retired_q;

        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (!stall) begin
            wb_valid_d    = mem_valid;
            wb_regwrite_d = mem_regwrite;
            wb_memtoreg_d = mem_memtoreg;
            wb_writereg_d = mem_writereg;
            wb_alu_d      = mem_aluresult;
            wb_rdata_d    = mem_readdata;
`ifdef WB_LOAD_EXT_EN
            wb_ltype_d    = mem_loadtype;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_writereg_q <= '0;
            wb_alu_q      <= '0;
            wb_rdata_q    <= '0;
`ifdef WB_LOAD_EXT_EN
            wb_ltype_q    <= 3'd0;
`endif
            retired_q     <= 32'd0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_writereg_q <= wb_writereg_d;
            wb_alu_q      <= wb_alu_d;
            wb_rdata_q    <= wb_rdata_d;
`ifdef WB_LOAD_EXT_EN
            wb_ltype_q    <= wb_ltype_d;
`endif
            retired_q     <= retired_d;
        end
    end

`ifdef WB_LOAD_EXT_EN
    load_align u_load_align (
        .rdata (wb_rdata_q),
        .addr  (wb_alu_q[1:0]),
        .ltype (wb_ltype_q),
        .data  (load_data)
    );
`else
    assign load_data = wb_rdata_q;
`endif

    assign mem_ready = reset_n & ~stall;
    assign writereg  = wb_writereg_q;
    assign writedata = wb_memtoreg_q ? load_data : wb_alu_q;
    assign write     = wb_valid_q & wb_regwrite_q & ~stall
                     & (wb_writereg_q != REG_W'(REG_ZERO));
    assign fwd_valid = write;
    assign fwd_reg   = writereg;
    assign fwd_data  = writedata;
    assign retired   = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage; load-extension cases run only when WB_LOAD_EXT_EN is defined.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, mem_ready, stall, flush;
    logic        mem_regwrite, mem_memtoreg;
    logic [4:0]  mem_writereg;
    logic [31:0] mem_aluresult, mem_readdata;
    logic [2:0]  mem_loadtype;
    logic [4:0]  writereg, fwd_reg;
    logic [31:0] writedata, fwd_data, retired;
    logic        write, fwd_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  rg;
        logic [31:0] dat;
        logic [31:0] ret;
        bit          chk_dat;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .stall         (stall),
        .flush         (flush),
        .mem_regwrite  (mem_regwrite),
        .mem_memtoreg  (mem_memtoreg),
        .mem_writereg  (mem_writereg),
        .mem_aluresult (mem_aluresult),
        .mem_readdata  (mem_readdata),
`ifdef WB_LOAD_EXT_EN
        .mem_loadtype  (mem_loadtype),
`endif
        .writereg      (writereg),
        .writedata     (writedata),
        .write         (write),
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data),
        .retired       (retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic set_in(input logic v, input logic rw, input logic m2r, input logic [4:0] rg,
                          input logic [31:0] alu, input logic [31:0] rd, input logic [2:0] lt,
                          input logic st, input logic fl);
        mem_valid     = v;
        mem_regwrite  = rw;
        mem_memtoreg  = m2r;
        mem_writereg  = rg;
        mem_aluresult = alu;
        mem_readdata  = rd;
        mem_loadtype  = lt;
        stall         = st;
        flush         = fl;
    endtask

    task automatic compare_out();
        exp_t e;
        e = exp_q.pop_front();
        check("write",     {31'd0, write},     {31'd0, e.wr});
        check("fwd_valid", {31'd0, fwd_valid}, {31'd0, e.wr});
        check("mem_ready", {31'd0, mem_ready}, {31'd0, e.rdy});
        check("retired",   retired,            e.ret);
        if (e.chk_dat) begin
            check("writereg",  {27'd0, writereg},  {27'd0, e.rg});
            check("fwd_reg",   {27'd0, fwd_reg},   {27'd0, e.rg});
            check("writedata", writedata,          e.dat);
            check("fwd_data",  fwd_data,           e.dat);
        end
    endtask

    // Drive this cycle's MEM inputs just after the edge; the expected WB outputs for the same cycle are checked at the falling edge.
    task automatic step(input logic v, input logic rw, input logic m2r, input logic [4:0] rg,
                        input logic [31:0] alu, input logic [31:0] rd, input logic [2:0] lt,
                        input logic st, input logic fl,
                        input logic ewr, input logic [4:0] erg, input logic [31:0] edat,
                        input logic [31:0] eret, input bit echk);
        exp_t e;
        @(posedge clk);
        #1;
        set_in(v, rw, m2r, rg, alu, rd, lt, st, fl);
        e.wr = ewr; e.rg = erg; e.dat = edat; e.ret = eret; e.chk_dat = echk; e.rdy = ~st;
        exp_q.push_back(e);
        @(negedge clk);
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 5'd0, 32'd0, 32'd0, 3'd0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_write",     {31'd0, write},     32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("rst_writereg",  {27'd0, writereg},  32'd0);
        check("rst_writedata", writedata,          32'd0);
        check("rst_fwd_data",  fwd_data,           32'd0);
        check("rst_retired",   retired,            32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        reset_n = 1'b1;

        // Basic writeback, then a $zero target that still retires.
        step(1, 1, 0, 5'd8,  32'h12345678, 32'd0, 3'd0, 0, 0,  0, 5'd0, 32'd0,        32'd0, 1);
        step(0, 0, 0, 5'd0,  32'd0,        32'd0, 3'd0, 0, 0,  1, 5'd8, 32'h12345678, 32'd0, 1);
        step(1, 1, 0, 5'd0,  32'hDEADBEEF, 32'd0, 3'd0, 0, 0,  0, 5'd0, 32'd0,        32'd1, 1);
        step(1, 1, 0, 5'd9,  32'h00000099, 32'd0, 3'd0, 0, 0,  0, 5'd0, 32'hDEADBEEF, 32'd1, 1);
        // Three stalled cycles on reg 9, then exactly one write.
        step(1, 1, 0, 5'd10, 32'h0000AAAA, 32'd0, 3'd0, 1, 0,  0, 5'd9, 32'h00000099, 32'd2, 1);
        step(1, 1, 0, 5'd10, 32'h0000AAAA, 32'd0, 3'd0, 1, 0,  0, 5'd9, 32'h00000099, 32'd2, 1);
        step(1, 1, 0, 5'd10, 32'h0000AAAA, 32'd0, 3'd0, 1, 0,  0, 5'd9, 32'h00000099, 32'd2, 1);
        step(0, 0, 0, 5'd0,  32'd0,        32'd0, 3'd0, 0, 0,  1, 5'd9, 32'h00000099, 32'd2, 1);
        step(1, 1, 0, 5'd11, 32'h00001111, 32'd0, 3'd0, 0, 0,  0, 5'd0, 32'd0,        32'd3, 1);
        // Flush together with stall drops the held entry.
        step(1, 1, 0, 5'd12, 32'h00002222, 32'd0, 3'd0, 1, 1,  0, 5'd11, 32'h00001111, 32'd3, 1);
        step(1, 1, 0, 5'd13, 32'h00003333, 32'd0, 3'd0, 0, 0,  0, 5'd0, 32'd0,        32'd3, 0);
        // Non-writing instruction retires; load passes raw data through as a word.
        step(1, 0, 0, 5'd14, 32'h00004444, 32'd0, 3'd0, 0, 0,  1, 5'd13, 32'h00003333, 32'd3, 1);
        step(1, 1, 1, 5'd15, 32'h00000003, 32'hCAFEF00D, 3'd0, 0, 0, 0, 5'd14, 32'h00004444, 32'd4, 1);
        step(0, 0, 0, 5'd0,  32'd0,        32'd0, 3'd0, 0, 0,  1, 5'd15, 32'hCAFEF00D, 32'd5, 1);
        step(0, 0, 0, 5'd0,  32'd0,        32'd0, 3'd0, 0, 0,  0, 5'd0, 32'd0,        32'd6, 1);
        // Reset while an entry is writing.
        step(1, 1, 0, 5'd16, 32'h00005555, 32'd0, 3'd0, 0, 0,  0, 5'd0, 32'd0,        32'd6, 1);
        step(0, 0, 0, 5'd0,  32'd0,        32'd0, 3'd0, 0, 0,  1, 5'd16, 32'h00005555, 32'd6, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_write",     {31'd0, write},    32'd0);
        check("midrst_writereg",  {27'd0, writereg}, 32'd0);
        check("midrst_writedata", writedata,         32'd0);
        check("midrst_retired",   retired,           32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0, 5'd0,  32'd0,        32'd0, 3'd0, 0, 0,  0, 5'd0, 32'd0,        32'd0, 1);

        // Counter wrap from all-ones.
        @(posedge clk);
        #1;
        force dut.retired_q = 32'hFFFFFFFF;
        set_in(1, 1, 0, 5'd17, 32'h00007777, 32'd0, 3'd0, 0, 0);
        #1;
        release dut.retired_q;
        @(negedge clk);
        check("preload_retired", retired, 32'hFFFFFFFF);
        step(0, 0, 0, 5'd0,  32'd0,        32'd0, 3'd0, 0, 0,  1, 5'd17, 32'h00007777, 32'hFFFFFFFF, 1);
        step(0, 0, 0, 5'd0,  32'd0,        32'd0, 3'd0, 0, 0,  0, 5'd0, 32'd0,        32'd0, 1);

`ifdef WB_LOAD_EXT_EN
        step(1, 1, 1, 5'd20, 32'h00000001, 32'h80FF7F01, 3'b001, 0, 0, 0, 5'd0, 32'd0, 32'd0, 1);
        step(1, 1, 1, 5'd20, 32'h00000000, 32'h80FF7F01, 3'b010, 0, 0, 1, 5'd20, 32'hFFFFFFFF, 32'd0, 1);
        step(1, 1, 1, 5'd20, 32'h00000002, 32'h80FF7F01, 3'b011, 0, 0, 1, 5'd20, 32'h00000080, 32'd1, 1);
        step(1, 1, 1, 5'd20, 32'h00000000, 32'h80FF7F01, 3'b100, 0, 0, 1, 5'd20, 32'h00007F01, 32'd2, 1);
        step(1, 1, 1, 5'd20, 32'h00000003, 32'h80FF7F01, 3'b011, 0, 0, 1, 5'd20, 32'h000080FF, 32'd3, 1);
        step(1, 1, 1, 5'd20, 32'h00000002, 32'h80FF7F01, 3'b111, 0, 0, 1, 5'd20, 32'h00007F01, 32'd4, 1);
        step(0, 0, 0, 5'd0,  32'd0,        32'd0,        3'd0,   0, 0, 1, 5'd20, 32'h80FF7F01, 32'd5, 1);
`endif

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
